// File: rtl/sd_mux_pkg.sv
// rtl/sd_mux_pkg.sv - shared types, constants and helpers for the SD SPI router
package sd_mux_pkg;

    // Largest supported number of virtual image slots and matching index width
    localparam int MAX_VSD   = 7;
    localparam int MAX_SEL_W = 3;

    // Target index: 0 is the physical card, k selects virtual slot k-1
    typedef logic [MAX_SEL_W-1:0] tgt_idx_t;

    localparam tgt_idx_t PHYS_TGT = '0;

    // Width needed to encode the physical card plus num_vsd virtual slots
    function automatic int sel_width(input int num_vsd);
        return (num_vsd < 1) ? 1 : $clog2(num_vsd + 1);
    endfunction

    // Highest set slot in mask as a target index, or the physical card when empty
    function automatic tgt_idx_t top_slot(input logic [MAX_VSD-1:0] mask);
        tgt_idx_t r;
        r = PHYS_TGT;
        for (int k = 0; k < MAX_VSD; k++) begin
            if (mask[k]) begin
                r = tgt_idx_t'(k + 1);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/sd_act_timer.sv
// rtl/sd_act_timer.sv - retriggerable countdown that holds its output high until expiry
module sd_act_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk_sys,
    input  logic reset_n,
    input  logic restart,
    output logic out
);

    localparam int            CW   = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LOAD = CW'(TIMEOUT);
    localparam logic [CW-1:0] ONE  = CW'(1);

    logic [CW-1:0] cnt;

    // Reload on restart, otherwise count down and stick at zero; out is high
    // exactly while the count that will be stored next is non-zero
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
            out <= 1'b0;
        end else if (restart) begin
            cnt <= LOAD;
            out <= 1'b1;
        end else begin
            if (cnt != '0) begin
                cnt <= cnt - ONE;
            end
            out <= (cnt > ONE);
        end
    end

endmodule

// File: rtl/sd_spi_mux.sv
// rtl/sd_spi_mux.sv - routes the core SPI master to the physical card or a virtual SD slot
module sd_spi_mux
    import sd_mux_pkg::*;
#(
    parameter int NUM_VSD          = 2,
    parameter int ACT_TIMEOUT      = 1_000_000,
    parameter int MOUNT_RST_CYCLES = 10_000_000,
    parameter int SEL_W            = sel_width(NUM_VSD)
) (
    input  logic               clk_sys,
    input  logic               reset_n,
    input  logic [NUM_VSD-1:0] img_mounted,
    input  logic [NUM_VSD-1:0] img_present,
    input  logic               spi_sck,
    input  logic               spi_mosi,
    input  logic               spi_cs_n,
    output logic               spi_miso,
    output logic [NUM_VSD-1:0] vsd_ss_n,
    input  logic [NUM_VSD-1:0] vsd_miso,
    output logic               SD_SCK,
    output logic               SD_MOSI,
    output logic               SD_CS,
    input  logic               SD_MISO,
    output logic [SEL_W-1:0]   sel,
    output logic [NUM_VSD:0]   act,
    output logic               reset_req
);

    logic [NUM_VSD-1:0] mounted;
    logic [NUM_VSD-1:0] mounted_nxt;
    logic [SEL_W-1:0]   pending;
    logic [SEL_W-1:0]   pending_nxt;
    logic [MAX_VSD-1:0] new_mask;
    logic [MAX_VSD-1:0] remain_mask;
    logic               pending_unmounted;
    logic               routed_miso;
    logic               mosi_q;
    logic               miso_q;
    logic               toggle;

    // Next mount state and next pending target from this cycle's strobes
    always_comb begin
        mounted_nxt       = mounted;
        new_mask          = '0;
        remain_mask       = '0;
        pending_unmounted = 1'b0;
        for (int k = 0; k < NUM_VSD; k++) begin
            if (img_mounted[k]) begin
                mounted_nxt[k] = img_present[k];
            end
        end
        for (int k = 0; k < NUM_VSD; k++) begin
            new_mask[k]    = img_mounted[k] & img_present[k];
            remain_mask[k] = mounted_nxt[k];
            if (img_mounted[k] && (pending == SEL_W'(k + 1))) begin
                pending_unmounted = 1'b1;
            end
        end
        pending_nxt = pending;
        if (new_mask != '0) begin
            pending_nxt = SEL_W'(top_slot(new_mask));
        end else if (pending_unmounted) begin
            pending_nxt = SEL_W'(top_slot(remain_mask));
        end
    end

    // Track mounts and pending target; only move sel while chip select is idle
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            mounted <= '0;
            pending <= SEL_W'(PHYS_TGT);
            sel     <= SEL_W'(PHYS_TGT);
        end else begin
            mounted <= mounted_nxt;
            pending <= pending_nxt;
            if (spi_cs_n) begin
                sel <= pending_nxt;
            end
        end
    end

    // Steer chip selects, clock, data and the returned MISO by the registered target
    always_comb begin
        SD_CS       = (sel != SEL_W'(PHYS_TGT)) | spi_cs_n;
        SD_SCK      = spi_sck & ~SD_CS;
        SD_MOSI     = spi_mosi & ~SD_CS;
        routed_miso = SD_MISO;
        for (int k = 0; k < NUM_VSD; k++) begin
            vsd_ss_n[k] = (sel != SEL_W'(k + 1)) | spi_cs_n;
            if (sel == SEL_W'(k + 1)) begin
                routed_miso = vsd_miso[k];
            end
        end
    end

    assign spi_miso = routed_miso;

    // Previous data line values, used to spot bus activity
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            mosi_q <= 1'b0;
            miso_q <= 1'b0;
        end else begin
            mosi_q <= spi_mosi;
            miso_q <= routed_miso;
        end
    end

    assign toggle = (spi_mosi ^ mosi_q) | (routed_miso ^ miso_q);

    // One activity timer per target; only the selected target is retriggered
    for (genvar t = 0; t <= NUM_VSD; t++) begin : g_act
        sd_act_timer #(
            .TIMEOUT (ACT_TIMEOUT)
        ) u_act_timer (
            .clk_sys (clk_sys),
            .reset_n (reset_n),
            .restart (toggle && (sel == SEL_W'(t))),
            .out     (act[t])
        );
    end

    // Any mount or unmount strobe (re)starts the cold-reset request window
    sd_act_timer #(
        .TIMEOUT (MOUNT_RST_CYCLES)
    ) u_rst_timer (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .restart (|img_mounted),
        .out     (reset_req)
    );

endmodule

// File: tb/tb_sd_spi_mux.sv
// tb/tb_sd_spi_mux.sv - self-checking bench for sd_spi_mux
module tb_sd_spi_mux;

    localparam int NV = 2;
    localparam int SW = 2;

    logic          clk_sys = 1'b0;
    logic          reset_n = 1'b0;
    logic [NV-1:0] img_mounted = '0;
    logic [NV-1:0] img_present = '0;
    logic          spi_sck = 1'b0;
    logic          spi_mosi = 1'b0;
    logic          spi_cs_n = 1'b1;
    logic          spi_miso;
    logic [NV-1:0] vsd_ss_n;
    logic [NV-1:0] vsd_miso = '0;
    logic          SD_SCK;
    logic          SD_MOSI;
    logic          SD_CS;
    logic          SD_MISO = 1'b0;
    logic [SW-1:0] sel;
    logic [NV:0]   act;
    logic          reset_req;

    int n_checks = 0;
    int n_fail   = 0;

    sd_spi_mux #(
        .NUM_VSD          (NV),
        .ACT_TIMEOUT      (16),
        .MOUNT_RST_CYCLES (32)
    ) dut (
        .clk_sys     (clk_sys),
        .reset_n     (reset_n),
        .img_mounted (img_mounted),
        .img_present (img_present),
        .spi_sck     (spi_sck),
        .spi_mosi    (spi_mosi),
        .spi_cs_n    (spi_cs_n),
        .spi_miso    (spi_miso),
        .vsd_ss_n    (vsd_ss_n),
        .vsd_miso    (vsd_miso),
        .SD_SCK      (SD_SCK),
        .SD_MOSI     (SD_MOSI),
        .SD_CS       (SD_CS),
        .SD_MISO     (SD_MISO),
        .sel         (sel),
        .act         (act),
        .reset_req   (reset_req)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct {
        logic [1:0] stb;
        logic [1:0] pres;
        logic       cs_n;
        logic [1:0] exp_sel;
    } vec_t;

    vec_t tbl[15];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic do_reset();
        reset_n     = 1'b0;
        img_mounted = '0;
        img_present = '0;
        spi_cs_n    = 1'b1;
        spi_mosi    = 1'b0;
        spi_sck     = 1'b0;
        SD_MISO     = 1'b0;
        vsd_miso    = '0;
        repeat (2) @(posedge clk_sys);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        logic       e_cs;
        logic [1:0] e_ss;
        logic       e_miso;
        int         hi;

        // stb, pres, cs_n, expected sel after the edge
        tbl[0]  = '{2'b00, 2'b00, 1'b1, 2'd0};
        tbl[1]  = '{2'b01, 2'b01, 1'b1, 2'd1};
        tbl[2]  = '{2'b00, 2'b00, 1'b0, 2'd1};
        tbl[3]  = '{2'b10, 2'b10, 1'b0, 2'd1};
        tbl[4]  = '{2'b00, 2'b00, 1'b0, 2'd1};
        tbl[5]  = '{2'b00, 2'b00, 1'b1, 2'd2};
        tbl[6]  = '{2'b10, 2'b00, 1'b1, 2'd1};
        tbl[7]  = '{2'b01, 2'b00, 1'b1, 2'd0};
        tbl[8]  = '{2'b11, 2'b11, 1'b1, 2'd2};
        tbl[9]  = '{2'b01, 2'b00, 1'b1, 2'd2};
        tbl[10] = '{2'b10, 2'b00, 1'b1, 2'd0};
        tbl[11] = '{2'b01, 2'b01, 1'b0, 2'd0};
        tbl[12] = '{2'b00, 2'b00, 1'b1, 2'd1};
        tbl[13] = '{2'b11, 2'b10, 1'b1, 2'd2};
        tbl[14] = '{2'b01, 2'b00, 1'b1, 2'd2};

        // Reset release with no strobes
        do_reset();
        check("rst_sel", 32'(sel), 32'd0);
        check("rst_act", 32'(act), 32'd0);
        check("rst_reset_req", 32'(reset_req), 32'd0);
        check("rst_sd_cs_idle", 32'(SD_CS), 32'd1);
        check("rst_vsd_ss_n", 32'(vsd_ss_n), 32'h3);
        spi_cs_n = 1'b0;
        spi_sck  = 1'b1;
        spi_mosi = 1'b1;
        #1;
        check("rst_sd_cs_active", 32'(SD_CS), 32'd0);
        check("rst_sd_sck", 32'(SD_SCK), 32'd1);
        check("rst_sd_mosi", 32'(SD_MOSI), 32'd1);
        spi_cs_n = 1'b1;
        spi_sck  = 1'b0;
        spi_mosi = 1'b0;
        #1;
        check("rst_sd_cs_back", 32'(SD_CS), 32'd1);
        check("rst_sd_sck_gated", 32'(SD_SCK), 32'd0);

        // Table: target selection and routing
        do_reset();
        SD_MISO  = 1'b1;
        vsd_miso = 2'b10;
        for (int i = 0; i < 15; i++) begin
            img_mounted = tbl[i].stb;
            img_present = tbl[i].pres;
            spi_cs_n    = tbl[i].cs_n;
            tick();
            e_cs   = (tbl[i].exp_sel != 2'd0) | tbl[i].cs_n;
            e_ss[0] = (tbl[i].exp_sel != 2'd1) | tbl[i].cs_n;
            e_ss[1] = (tbl[i].exp_sel != 2'd2) | tbl[i].cs_n;
            e_miso = (tbl[i].exp_sel == 2'd0) ? 1'b1 : (tbl[i].exp_sel == 2'd1) ? 1'b0 : 1'b1;
            check($sformatf("tbl%0d_sel", i), 32'(sel), 32'(tbl[i].exp_sel));
            check($sformatf("tbl%0d_sd_cs", i), 32'(SD_CS), 32'(e_cs));
            check($sformatf("tbl%0d_vsd_ss_n", i), 32'(vsd_ss_n), 32'(e_ss));
            check($sformatf("tbl%0d_miso", i), 32'(spi_miso), 32'(e_miso));
        end
        img_mounted = '0;
        img_present = '0;

        // Mount slot 1: sel moves next cycle, reset_req high for exactly 32 cycles
        do_reset();
        img_mounted = 2'b01;
        img_present = 2'b01;
        tick();
        img_mounted = '0;
        img_present = '0;
        check("mnt_sel", 32'(sel), 32'd1);
        check("mnt_sd_cs", 32'(SD_CS), 32'd1);
        check("mnt_reset_req_rise", 32'(reset_req), 32'd1);
        hi = 1;
        for (int c = 0; c < 100 && reset_req; c++) begin
            tick();
            if (reset_req) hi++;
        end
        check("mnt_reset_req_len", 32'(hi), 32'd32);

        // Single mosi toggle with sel=1: act=010 for 16 cycles
        repeat (5) tick();
        check("act_idle", 32'(act), 32'd0);
        spi_mosi = ~spi_mosi;
        tick();
        for (int c = 0; c <= 20; c++) begin
            check($sformatf("act1_c%0d", c), 32'(act), (c <= 15) ? 32'h2 : 32'h0);
            tick();
        end

        // Second toggle at cycle 10 extends act to cycle 26
        repeat (3) tick();
        spi_mosi = ~spi_mosi;
        tick();
        for (int c = 0; c <= 30; c++) begin
            check($sformatf("act2_c%0d", c), 32'(act), (c <= 25) ? 32'h2 : 32'h0);
            if (c == 9) spi_mosi = ~spi_mosi;
            tick();
        end

        // Retriggered reset request: strobes at t0 and t0+20, high until t0+52
        img_mounted = 2'b01;
        img_present = 2'b01;
        tick();
        img_mounted = '0;
        for (int c = 0; c <= 55; c++) begin
            check($sformatf("rtrg_c%0d", c), 32'(reset_req), (c < 52) ? 32'd1 : 32'd0);
            img_mounted = (c == 19) ? 2'b01 : 2'b00;
            tick();
        end
        img_mounted = '0;
        img_present = '0;

        // Async reset mid-count and mid-transaction
        img_mounted = 2'b01;
        img_present = 2'b01;
        tick();
        img_mounted = '0;
        repeat (5) tick();
        check("arst_pre_reset_req", 32'(reset_req), 32'd1);
        spi_cs_n = 1'b0;
        #1;
        check("arst_pre_sd_cs", 32'(SD_CS), 32'd1);
        check("arst_pre_vsd_ss_n", 32'(vsd_ss_n), 32'h2);
        reset_n = 1'b0;
        #1;
        check("arst_reset_req", 32'(reset_req), 32'd0);
        check("arst_sel", 32'(sel), 32'd0);
        check("arst_sd_cs", 32'(SD_CS), 32'd0);
        check("arst_vsd_ss_n", 32'(vsd_ss_n), 32'h3);
        check("arst_act", 32'(act), 32'd0);
        spi_cs_n = 1'b1;
        tick();
        reset_n = 1'b1;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
